player_cmd_seq: RTL and testbench

PLAYER_CMD_SEQ -- requirements
Module: player_cmd_seq

---
 rtl/bomber_pkg.sv | 47 ++++
 rtl/player_cmd_seq_cmd_channel.sv | 129 ++++++++++++
 rtl/player_cmd_seq.sv | 80 ++++++++
 tb/tb_player_cmd_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bomber_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bomber_pkg
//  Description : Shared command codes, keypad codes and per-channel FSM state
//                encoding for the player command sequencer, plus the
//                request priority helper (BOMB > UP > DOWN > LEFT > RIGHT).
//  Revision    : 1.0 - initial release
// ============================================================================
package bomber_pkg;

   // Command codes presented on cmdA / cmdB
   localparam logic [2:0] cCmdNone  = 3'd0;
   localparam logic [2:0] cCmdUp    = 3'd1;
   localparam logic [2:0] cCmdDown  = 3'd2;
   localparam logic [2:0] cCmdLeft  = 3'd3;
   localparam logic [2:0] cCmdRight = 3'd4;
   localparam logic [2:0] cCmdBomb  = 3'd5;

   // Player-B keypad decode values
   localparam logic [3:0] cKeyUp    = 4'd2;
   localparam logic [3:0] cKeyDown  = 4'd8;
   localparam logic [3:0] cKeyLeft  = 4'd4;
   localparam logic [3:0] cKeyRight = 4'd6;
   localparam logic [3:0] cKeyBomb  = 4'd5;

   // Channel FSM states
   localparam logic [1:0] cStIdle   = 2'd0;
   localparam logic [1:0] cStDelay  = 2'd1;
   localparam logic [1:0] cStRepeat = 2'd2;
   localparam logic [1:0] cStBhold  = 2'd3;

   // Collapse simultaneous raw inputs to a single request code.
   function automatic logic [2:0] prioReq(input logic bomb, input logic up,
                                          input logic down, input logic left,
                                          input logic right);
      logic [2:0] r;
      if (bomb)       r = cCmdBomb;
      else if (up)    r = cCmdUp;
      else if (down)  r = cCmdDown;
      else if (left)  r = cCmdLeft;
      else if (right) r = cCmdRight;
      else            r = cCmdNone;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/player_cmd_seq_cmd_channel.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_channel
//  Description : One player's command channel: press/auto-repeat FSM, repeat
//                counter, bomb cooldown counter and the cmd/valid register
//                with ready handshake.
//  Ports       : clk, rst (async, active-low), tick (timing strobe),
//                gameOver (freeze + flush), req (prioritised request code),
//                ready (consumer accept) -> cmd (3b), valid
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_channel
   import bomber_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 4,
   parameter int unsigned REPEAT_RATE   = 2,
   parameter int unsigned BOMB_COOLDOWN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       gameOver,
   input  logic [2:0] req,
   input  logic       ready,
   output logic [2:0] cmd,
   output logic       valid
);

   localparam logic [3:0] cDelay = 4'(REPEAT_DELAY);
   localparam logic [3:0] cRate  = 4'(REPEAT_RATE);
   localparam logic [3:0] cCool  = 4'(BOMB_COOLDOWN);

   logic [1:0] rState, wNextState;
   logic [3:0] rCnt, wNextCnt;
   logic [3:0] rCool, wNextCool;
   logic [2:0] rDir, wNextDir;
   logic [2:0] rCmd;
   logic       rValid;
   logic       wIssue;
   logic [2:0] wIssueCmd;
   logic       wAccept;

   // A new command may overwrite the register when it is empty or is being
   // consumed this very cycle.
   assign wAccept = !rValid || ready;

   always_comb begin
      wNextState = rState;
      wNextCnt   = rCnt;
      wNextDir   = rDir;
      wNextCool  = rCool;
      wIssue     = 1'b0;
      wIssueCmd  = cCmdNone;

      if (tick && (rCool != 4'd0))
         wNextCool = rCool - 4'd1;

      if (gameOver) begin
         // Force IDLE so a key still held afterwards counts as a new press;
         // both counters hold their value.
         wNextState = cStIdle;
         wNextCool  = rCool;
      end else if (req == cCmdBomb) begin
         // Only the transition into BHOLD may fire a bomb; holding the key
         // never produces a second one.
         if (rState != cStBhold) begin
            wNextState = cStBhold;
            if (rCool == 4'd0) begin
               wIssue    = 1'b1;
               wIssueCmd = cCmdBomb;
               if (wAccept)
                  wNextCool = cCool;
            end
         end
      end else if (req == cCmdNone) begin
         wNextState = cStIdle;
      end else begin
         if ((rState == cStIdle) || (rState == cStBhold) || (req != rDir)) begin
            wIssue     = 1'b1;
            wIssueCmd  = req;
            wNextDir   = req;
            wNextCnt   = cDelay;
            wNextState = cStDelay;
         end else if (tick) begin
            // A count of 1 reaches zero on this tick; 0 (zero-valued
            // parameter) fires immediately. Never wraps below zero.
            if (rCnt <= 4'd1) begin
               wIssue     = 1'b1;
               wIssueCmd  = rDir;
               wNextCnt   = cRate;
               wNextState = cStRepeat;
            end else begin
               wNextCnt = rCnt - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rState <= cStIdle;
         rCnt   <= 4'd0;
         rCool  <= 4'd0;
         rDir   <= cCmdNone;
         rCmd   <= cCmdNone;
         rValid <= 1'b0;
      end else begin
         rState <= wNextState;
         rCnt   <= wNextCnt;
         rCool  <= wNextCool;
         rDir   <= wNextDir;
         if (gameOver) begin
            rCmd   <= cCmdNone;
            rValid <= 1'b0;
         end else if (wIssue && wAccept) begin
            rCmd   <= wIssueCmd;
            rValid <= 1'b1;
         end else if (rValid && ready) begin
            rCmd   <= cCmdNone;
            rValid <= 1'b0;
         end
      end
   end

   assign cmd   = rCmd;
   assign valid = rValid;

endmodule
`default_nettype wire

// File: rtl/player_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : player_cmd_seq
//  Description : Two-player command sequencer. Player A uses discrete
//                buttons, player B a decoded keypad; each is prioritised
//                into a single request and fed to its own cmd_channel.
//  Ports       : clk, rst (async, active-low), tick,
//                btnU/btnD/btnL/btnR/btnS (player A), keyB[3:0] (player B),
//                game_state[1:0] (0 = running),
//                cmdA/cmdB[2:0] + cmdA_valid/cmdB_valid out,
//                cmdA_ready/cmdB_ready in
//  Revision    : 1.0 - initial release
// ============================================================================
module player_cmd_seq
   import bomber_pkg::*;
#(
   parameter int unsigned REPEAT_DELAY  = 4,
   parameter int unsigned REPEAT_RATE   = 2,
   parameter int unsigned BOMB_COOLDOWN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       btnU,
   input  logic       btnD,
   input  logic       btnL,
   input  logic       btnR,
   input  logic       btnS,
   input  logic [3:0] keyB,
   input  logic [1:0] game_state,
   output logic [2:0] cmdA,
   output logic [2:0] cmdB,
   output logic       cmdA_valid,
   output logic       cmdB_valid,
   input  logic       cmdA_ready,
   input  logic       cmdB_ready
);

   logic       wGameOver;
   logic [2:0] wReqA;
   logic [2:0] wReqB;

   assign wGameOver = |game_state;
   assign wReqA = prioReq(btnS, btnU, btnD, btnL, btnR);
   // Keypad values outside the five defined codes fall through to NONE.
   assign wReqB = prioReq(keyB == cKeyBomb, keyB == cKeyUp, keyB == cKeyDown,
                          keyB == cKeyLeft, keyB == cKeyRight);

   cmd_channel #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .BOMB_COOLDOWN(BOMB_COOLDOWN)
   ) uChanA (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .gameOver(wGameOver),
      .req     (wReqA),
      .ready   (cmdA_ready),
      .cmd     (cmdA),
      .valid   (cmdA_valid)
   );

   cmd_channel #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .BOMB_COOLDOWN(BOMB_COOLDOWN)
   ) uChanB (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .gameOver(wGameOver),
      .req     (wReqB),
      .ready   (cmdB_ready),
      .cmd     (cmdB),
      .valid   (cmdB_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_player_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_cmd_seq
//  Description : Self-checking bench for player_cmd_seq: a table of single-
//                cycle vectors followed by multi-cycle scenario sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_cmd_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnS = 1'b0;
   logic [3:0] keyB = 4'd0;
   logic [1:0] game_state = 2'd0;
   logic [2:0] cmdA, cmdB;
   logic       cmdA_valid, cmdB_valid;
   logic       cmdA_ready = 1'b1, cmdB_ready = 1'b1;

   int nCompared   = 0;
   int nMismatched = 0;

   player_cmd_seq #(
      .REPEAT_DELAY (4),
      .REPEAT_RATE  (2),
      .BOMB_COOLDOWN(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .btnU      (btnU),
      .btnD      (btnD),
      .btnL      (btnL),
      .btnR      (btnR),
      .btnS      (btnS),
      .keyB      (keyB),
      .game_state(game_state),
      .cmdA      (cmdA),
      .cmdB      (cmdB),
      .cmdA_valid(cmdA_valid),
      .cmdB_valid(cmdB_valid),
      .cmdA_ready(cmdA_ready),
      .cmdB_ready(cmdB_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] btn;   // {U, D, L, R, S}
      logic [3:0] key;
      logic [2:0] expA;
      logic       expVA;
      logic [2:0] expB;
      logic       expVB;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOut(input string name, input logic [2:0] eA, input logic eVA,
                           input logic [2:0] eB, input logic eVB);
      chk({name, " cmdA"},       {1'b0, cmdA},       {1'b0, eA});
      chk({name, " cmdA_valid"}, {3'b0, cmdA_valid}, {3'b0, eVA});
      chk({name, " cmdB"},       {1'b0, cmdB},       {1'b0, eB});
      chk({name, " cmdB_valid"}, {3'b0, cmdB_valid}, {3'b0, eVB});
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tickCycle();
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
   endtask

   task automatic clearInputs();
      {btnU, btnD, btnL, btnR, btnS} = 5'b0;
      keyB = 4'd0;
      game_state = 2'd0;
      tick = 1'b0;
   endtask

   task automatic doReset();
      clearInputs();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{5'b00000, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0};
      vecs[1]  = '{5'b10000, 4'd0, 3'd1, 1'b1, 3'd0, 1'b0};
      vecs[2]  = '{5'b10000, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0};
      vecs[3]  = '{5'b01000, 4'd0, 3'd2, 1'b1, 3'd0, 1'b0};
      vecs[4]  = '{5'b01100, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0};
      vecs[5]  = '{5'b00110, 4'd4, 3'd3, 1'b1, 3'd3, 1'b1};
      vecs[6]  = '{5'b00010, 4'd6, 3'd4, 1'b1, 3'd4, 1'b1};
      vecs[7]  = '{5'b00000, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0};
      vecs[8]  = '{5'b00000, 4'd2, 3'd0, 1'b0, 3'd1, 1'b1};
      vecs[9]  = '{5'b00000, 4'd8, 3'd0, 1'b0, 3'd2, 1'b1};
      vecs[10] = '{5'b00000, 4'd7, 3'd0, 1'b0, 3'd0, 1'b0};
      vecs[11] = '{5'b10001, 4'd5, 3'd5, 1'b1, 3'd5, 1'b1};
      vecs[12] = '{5'b10000, 4'd0, 3'd1, 1'b1, 3'd0, 1'b0};
      vecs[13] = '{5'b00000, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0};
      vecs[14] = '{5'b00001, 4'd5, 3'd0, 1'b0, 3'd0, 1'b0};
      vecs[15] = '{5'b00000, 4'd0, 3'd0, 1'b0, 3'd0, 1'b0};

      // Reset state, held key during reset must not issue
      btnU = 1'b1;
      #2;
      checkOut("in reset", 3'd0, 1'b0, 3'd0, 1'b0);
      doReset();
      checkOut("after reset", 3'd0, 1'b0, 3'd0, 1'b0);

      // Single-cycle vector table, ready held high on both channels
      doReset();
      cmdA_ready = 1'b1;
      cmdB_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         {btnU, btnD, btnL, btnR, btnS} = vecs[i].btn;
         keyB = vecs[i].key;
         step();
         checkOut($sformatf("vec%0d", i), vecs[i].expA, vecs[i].expVA,
                  vecs[i].expB, vecs[i].expVB);
      end

      // Auto-repeat: hold UP for 12 ticks, repeats at 4,6,8,10,12
      doReset();
      btnU = 1'b1;
      step();
      checkOut("rep press", 3'd1, 1'b1, 3'd0, 1'b0);
      for (int n = 1; n <= 12; n++) begin
         logic rep;
         rep = (n >= 4) && (n % 2 == 0);
         tick = 1'b1;
         step();
         tick = 1'b0;
         checkOut($sformatf("rep tick%0d", n), rep ? 3'd1 : 3'd0, rep, 3'd0, 1'b0);
         step();
         checkOut($sformatf("rep gap%0d", n), 3'd0, 1'b0, 3'd0, 1'b0);
      end

      // Bomb held 20 ticks gives one bomb; cooldown suppresses early re-press
      doReset();
      keyB = 4'd5;
      step();
      checkOut("bomb first", 3'd0, 1'b0, 3'd5, 1'b1);
      for (int n = 1; n <= 20; n++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         checkOut($sformatf("bomb hold%0d", n), 3'd0, 1'b0, 3'd0, 1'b0);
         step();
      end
      keyB = 4'd0;
      step();
      keyB = 4'd5;
      step();
      checkOut("bomb second", 3'd0, 1'b0, 3'd5, 1'b1);
      keyB = 4'd0;
      step();
      for (int n = 0; n < 3; n++) tickCycle();
      keyB = 4'd5;
      step();
      checkOut("bomb cooldown", 3'd0, 1'b0, 3'd0, 1'b0);
      keyB = 4'd0;
      step();
      for (int n = 0; n < 6; n++) tickCycle();
      keyB = 4'd5;
      step();
      checkOut("bomb after cool", 3'd0, 1'b0, 3'd5, 1'b1);
      keyB = 4'd0;
      step();

      // Backpressure: L held pending, R dropped, one ready cycle clears
      doReset();
      cmdA_ready = 1'b0;
      btnL = 1'b1;
      step();
      checkOut("bp left", 3'd3, 1'b1, 3'd0, 1'b0);
      btnL = 1'b0;
      btnR = 1'b1;
      step();
      checkOut("bp right dropped", 3'd3, 1'b1, 3'd0, 1'b0);
      step();
      checkOut("bp hold", 3'd3, 1'b1, 3'd0, 1'b0);
      cmdA_ready = 1'b1;
      step();
      cmdA_ready = 1'b0;
      checkOut("bp clear", 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOut("bp stay clear", 3'd0, 1'b0, 3'd0, 1'b0);

      // Game over during REPEAT flushes output; held key re-issues afterwards
      doReset();
      cmdA_ready = 1'b0;
      btnU = 1'b1;
      step();
      checkOut("go press", 3'd1, 1'b1, 3'd0, 1'b0);
      for (int n = 0; n < 5; n++) tickCycle();
      checkOut("go repeat", 3'd1, 1'b1, 3'd0, 1'b0);
      game_state = 2'd1;
      step();
      checkOut("go flush", 3'd0, 1'b0, 3'd0, 1'b0);
      cmdA_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         tickCycle();
         checkOut($sformatf("go frozen%0d", n), 3'd0, 1'b0, 3'd0, 1'b0);
      end
      game_state = 2'd0;
      step();
      checkOut("go resume", 3'd1, 1'b1, 3'd0, 1'b0);

      // Asynchronous reset mid-DELAY with valid high
      doReset();
      cmdA_ready = 1'b0;
      btnU = 1'b1;
      step();
      checkOut("ar press", 3'd1, 1'b1, 3'd0, 1'b0);
      rst = 1'b0;
      #1;
      checkOut("ar async", 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      checkOut("ar held", 3'd0, 1'b0, 3'd0, 1'b0);
      rst = 1'b1;
      step();
      checkOut("ar reissue", 3'd1, 1'b1, 3'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
`default_nettype wire
